serial_rx_fifo: RTL and testbench

//  8N1 asynchronous serial receiver with a receive FIFO, feeding the ACIA register block.

---
 rtl/serial_rx_fifo.sv | 157 +++++++++++++++
 tb/tb_serial_rx_fifo.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_rx_fifo.sv
// rtl/serial_rx_fifo.sv - 8N1 serial receiver with show-ahead receive FIFO
module serial_rx_fifo #(
  parameter int CLK_DIV = 104,
  parameter int DEPTH   = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     rx,
  input  logic                     rx_pop,
  input  logic                     clr_err,
  output logic [7:0]               rx_data,
  output logic                     rx_valid,
  output logic [$clog2(DEPTH):0]   rx_count,
  output logic                     overrun,
  output logic                     frame_err,
  output logic                     rx_busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [15:0] T_FULL = 16'(CLK_DIV - 1);
  localparam logic [15:0] T_HALF = 16'(CLK_DIV / 2 - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

  state_t         r_state;
  logic           r_sync1;
  logic           r_rxs;
  logic [15:0]    r_timer;
  logic [2:0]     r_bitidx;
  logic [7:0]     r_shift;
  logic           r_push;
  logic [7:0]     r_push_data;
  logic           r_frame_err;

  logic [7:0]     r_mem [DEPTH];
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [CW-1:0]  r_count;
  logic           r_overrun;

  logic w_full;
  logic w_empty;
  logic w_pop;
  logic w_push;
  logic w_tick;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_rxs   <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_rxs   <= r_sync1;
    end
  end

  assign w_tick = (r_timer == 16'd0);

  // Accepted bytes are handed to the FIFO one cycle later through r_push.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_timer     <= 16'd0;
      r_bitidx    <= 3'd0;
      r_shift     <= 8'h00;
      r_push      <= 1'b0;
      r_push_data <= 8'h00;
      r_frame_err <= 1'b0;
    end else begin
      r_push <= 1'b0;
      if (clr_err) r_frame_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!r_rxs) begin
            r_state <= S_START;
            r_timer <= T_HALF;
          end
        end
        S_START: begin
          if (!w_tick) begin
            r_timer <= r_timer - 16'd1;
          end else if (r_rxs) begin
            r_state <= S_IDLE;
          end else begin
            r_state  <= S_DATA;
            r_bitidx <= 3'd0;
            r_timer  <= T_FULL;
          end
        end
        S_DATA: begin
          if (!w_tick) begin
            r_timer <= r_timer - 16'd1;
          end else begin
            r_shift <= {r_rxs, r_shift[7:1]};
            r_timer <= T_FULL;
            if (r_bitidx == 3'd7) r_state <= S_STOP;
            else r_bitidx <= r_bitidx + 3'd1;
          end
        end
        S_STOP: begin
          if (!w_tick) begin
            r_timer <= r_timer - 16'd1;
          end else if (r_rxs) begin
            r_push      <= 1'b1;
            r_push_data <= r_shift;
            r_state     <= S_IDLE;
          end else begin
            r_frame_err <= 1'b1;
            r_state     <= S_BREAK;
          end
        end
        S_BREAK: begin
          if (r_rxs) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_pop   = rx_pop && !w_empty;
  // A simultaneous pop frees the slot, so a full FIFO still accepts the push.
  assign w_push  = r_push && (!w_full || w_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= 8'h00;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= r_push_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (r_push && !w_push) r_overrun <= 1'b1;
      else if (clr_err)      r_overrun <= 1'b0;
    end
  end

  assign rx_data   = r_mem[r_rd_ptr];
  assign rx_valid  = !w_empty;
  assign rx_count  = r_count;
  assign overrun   = r_overrun;
  assign frame_err = r_frame_err;
  assign rx_busy   = (r_state != S_IDLE);

endmodule

// File: tb/tb_serial_rx_fifo.sv
// tb/tb_serial_rx_fifo.sv - scoreboard bench for serial_rx_fifo
module tb_serial_rx_fifo;

  localparam int CD    = 104;
  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic       rx_pop = 1'b0;
  logic       clr_err = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [4:0] rx_count;
  logic       overrun;
  logic       frame_err;
  logic       rx_busy;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  serial_rx_fifo #(.CLK_DIV(CD), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .rx(rx), .rx_pop(rx_pop), .clr_err(clr_err),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_count(rx_count),
    .overrun(overrun), .frame_err(frame_err), .rx_busy(rx_busy)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_v);
    rx = 1'b0;
    tick(CD);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      tick(CD);
    end
    rx = stop_v;
    tick(CD);
  endtask

  task automatic pop;
    rx_pop = 1'b1;
    tick(1);
    rx_pop = 1'b0;
    tick(1);
  endtask

  always @(negedge clk) begin
    if (!reset && rx_pop && rx_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_byte actual=%0h expected=none", rx_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (rx_data !== e) begin
          errors++;
          $display("FAIL pop_data actual=%0h expected=%0h", rx_data, e);
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic ok;

    tick(3);
    check("rst_valid", rx_valid, 0);
    check("rst_data", rx_data, 8'h00);
    check("rst_count", rx_count, 0);
    check("rst_overrun", overrun, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_busy", rx_busy, 0);
    reset = 1'b0;
    tick(5);

    // Single byte with latency bound
    exp_q.push_back(8'h55);
    lat = -1;
    fork
      send_frame(8'h55, 1'b1);
      begin
        for (int c = 1; c <= 10 * CD + 4; c++) begin
          tick(1);
          if (rx_valid && lat < 0) lat = c;
        end
      end
    join
    check("t1_latency_ok", (lat > 0 && lat <= 10 * CD + 4), 1);
    check("t1_count", rx_count, 1);
    pop();
    check("t1_valid_after_pop", rx_valid, 0);

    // Start-bit glitch
    rx = 1'b0;
    tick(20);
    check("t2_busy_during", rx_busy, 1);
    tick(10);
    rx = 1'b1;
    tick(30);
    check("t2_busy_idle", rx_busy, 0);
    check("t2_count", rx_count, 0);
    check("t2_frame_err", frame_err, 0);

    // Overflow by one
    for (int i = 0; i < 17; i++) begin
      if (i < 16) exp_q.push_back(8'(i));
      send_frame(8'(i), 1'b1);
    end
    tick(4);
    check("t3_count_full", rx_count, 16);
    check("t3_overrun", overrun, 1);
    for (int i = 0; i < 16; i++) pop();
    check("t3_valid_empty", rx_valid, 0);
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    tick(1);
    check("t3_overrun_clr", overrun, 0);

    // Framing error followed by a held-low line
    send_frame(8'hA3, 1'b0);
    tick(CD);
    check("t4_frame_err", frame_err, 1);
    check("t4_busy_break", rx_busy, 1);
    check("t4_no_push", rx_count, 0);
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    tick(2);
    check("t4_err_cleared", frame_err, 0);
    tick(2 * CD - 3);
    rx = 1'b1;
    tick(CD);
    check("t4_single_err", frame_err, 0);
    check("t4_busy_idle", rx_busy, 0);
    exp_q.push_back(8'h41);
    send_frame(8'h41, 1'b1);
    tick(4);
    check("t4_count_good", rx_count, 1);
    pop();

    // Full FIFO with pop on the push cycle
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(8'h20 + 8'(i));
      send_frame(8'h20 + 8'(i), 1'b1);
    end
    tick(4);
    check("t5_count_full", rx_count, 16);
    exp_q.push_back(8'h30);
    ok = 1'b0;
    fork
      send_frame(8'h30, 1'b1);
      begin
        logic seen;
        seen = 1'b0;
        for (int c = 0; c < 12 * CD && !ok; c++) begin
          tick(1);
          if (rx_busy) seen = 1'b1;
          else if (seen) begin
            rx_pop = 1'b1;
            tick(1);
            rx_pop = 1'b0;
            ok = 1'b1;
          end
        end
      end
    join
    check("t5_push_seen", ok, 1);
    tick(2);
    check("t5_count_kept", rx_count, 16);
    check("t5_no_overrun", overrun, 0);
    for (int i = 0; i < 16; i++) pop();
    check("t5_valid_empty", rx_valid, 0);

    // Reset mid-frame with bytes queued
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    tick(4);
    check("t6_count_pre", rx_count, 2);
    rx = 1'b0;
    tick(CD);
    rx = 1'b1;
    tick(3 * CD);
    check("t6_busy_mid", rx_busy, 1);
    reset = 1'b1;
    #1;
    check("t6_rst_valid", rx_valid, 0);
    check("t6_rst_data", rx_data, 8'h00);
    check("t6_rst_count", rx_count, 0);
    check("t6_rst_busy", rx_busy, 0);
    check("t6_rst_overrun", overrun, 0);
    check("t6_rst_frame_err", frame_err, 0);
    tick(3);
    reset = 1'b0;
    tick(5);
    exp_q.push_back(8'h7E);
    send_frame(8'h7E, 1'b1);
    tick(4);
    check("t6_count_post", rx_count, 1);
    pop();
    check("t6_valid_empty", rx_valid, 0);
    check("t6_frame_err_post", frame_err, 0);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
